// File: rtl/pr_req_capture_if.sv
// rtl/pr_req_capture_if.sv - request/grant bundle between requester logic and pr_req_capture
interface pr_req_capture_if;
  logic [7:0] req;
  logic [7:0] mask;
  logic       ack;
  logic       valid;
  logic [2:0] code;
  logic [7:0] pend;

  modport master (
    output req, mask, ack,
    input  valid, code, pend
  );

  modport slave (
    input  req, mask, ack,
    output valid, code, pend
  );
endinterface

// File: rtl/pr_req_capture.sv
// rtl/pr_req_capture.sv - latches request lines and presents the highest eligible index until ack
// Optional macro PR_REQ_EDGE_EN: capture only rising edges of req instead of levels.
module pr_req_capture (
  input  logic               clk,
  input  logic               rst_n,
  pr_req_capture_if.slave    bus
);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_PRESENT = 1'b1;

  logic [0:0] r_state;
  logic [2:0] r_code;
  logic [7:0] r_pend;

  logic [7:0] w_cap;
  logic [7:0] w_clr;
  logic [7:0] w_elig;
  logic [2:0] w_win;
  logic       w_ack_hit;

`ifdef PR_REQ_EDGE_EN
  logic [7:0] r_req_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_d <= 8'h00;
    end else begin
      r_req_d <= bus.req;
    end
  end

  assign w_cap = bus.req & ~r_req_d;
`else
  assign w_cap = bus.req;
`endif

  assign w_ack_hit = (r_state == S_PRESENT) && bus.ack;
  assign w_clr     = w_ack_hit ? (8'h01 << r_code) : 8'h00;
  assign w_elig    = r_pend & ~bus.mask;

  // Ascending scan so the highest set index is the last one written.
  always_comb begin
    w_win = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (w_elig[i]) begin
        w_win = 3'(i);
      end
    end
  end

  // Capture is OR-ed in after the clear so a same-edge set survives the ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= 8'h00;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_cap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_code  <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_elig != 8'h00) begin
            r_code  <= w_win;
            r_state <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (bus.ack) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.valid = (r_state == S_PRESENT);
  assign bus.code  = r_code;
  assign bus.pend  = r_pend;

endmodule

// File: tb/tb_pr_req_capture.sv
// tb/tb_pr_req_capture.sv - vector table plus grant scoreboard for pr_req_capture
module tb_pr_req_capture;

  logic clk;
  logic rst_n;

  pr_req_capture_if bus ();

  pr_req_capture dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    logic       exp_valid;
    logic [2:0] exp_code;
    logic [7:0] exp_pend;
  } vec_t;

  vec_t       vecs[27];
  int         n_chk;
  int         n_fail;
  logic [2:0] sb_q[$];
  logic       sb_en;
  logic       mon_prev_valid;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [7:0] r, input logic [7:0] m, input logic a);
    bus.req  = r;
    bus.mask = m;
    bus.ack  = a;
  endtask

  task automatic cyc_chk(input string name, input logic v, input logic [2:0] c, input logic [7:0] p);
    @(posedge clk);
    @(negedge clk);
    chk({name, ".valid"}, {31'd0, bus.valid}, {31'd0, v});
    if (v) chk({name, ".code"}, {29'd0, bus.code}, {29'd0, c});
    chk({name, ".pend"}, {24'd0, bus.pend}, {24'd0, p});
  endtask

  // Grant monitor: every rising valid must match the next queued expected code.
  always @(negedge clk) begin
    if (sb_en && bus.valid && !mon_prev_valid) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected_grant: got code %0d expected no grant at %0t", bus.code, $time);
      end else begin
        chk("sb_grant_code", {29'd0, bus.code}, {29'd0, sb_q.pop_front()});
      end
    end
    mon_prev_valid = bus.valid;
  end

  initial begin
    n_chk          = 0;
    n_fail         = 0;
    sb_en          = 1'b0;
    mon_prev_valid = 1'b0;
    rst_n          = 1'b0;
    drive(8'h00, 8'h00, 1'b0);

    //            req    mask   ack   v     code  pend
    vecs[0]  = '{8'h01, 8'h00, 1'b0, 1'b0, 3'd0, 8'h01};
    vecs[1]  = '{8'h00, 8'h00, 1'b0, 1'b1, 3'd0, 8'h01};
    vecs[2]  = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00};
    vecs[3]  = '{8'h24, 8'h00, 1'b0, 1'b0, 3'd0, 8'h24};
    vecs[4]  = '{8'h00, 8'h00, 1'b0, 1'b1, 3'd5, 8'h24};
    vecs[5]  = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd5, 8'h04};
    vecs[6]  = '{8'h00, 8'h00, 1'b0, 1'b1, 3'd2, 8'h04};
    vecs[7]  = '{8'h80, 8'h00, 1'b0, 1'b1, 3'd2, 8'h84};
    vecs[8]  = '{8'h00, 8'h00, 1'b0, 1'b1, 3'd2, 8'h84};
    vecs[9]  = '{8'h00, 8'h00, 1'b0, 1'b1, 3'd2, 8'h84};
    vecs[10] = '{8'h00, 8'h00, 1'b0, 1'b1, 3'd2, 8'h84};
    vecs[11] = '{8'h00, 8'h00, 1'b0, 1'b1, 3'd2, 8'h84};
    vecs[12] = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd2, 8'h80};
    vecs[13] = '{8'h00, 8'h00, 1'b0, 1'b1, 3'd7, 8'h80};
    vecs[14] = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd7, 8'h00};
    vecs[15] = '{8'h81, 8'h80, 1'b0, 1'b0, 3'd7, 8'h81};
    vecs[16] = '{8'h00, 8'h80, 1'b0, 1'b1, 3'd0, 8'h81};
    vecs[17] = '{8'h00, 8'h80, 1'b1, 1'b0, 3'd0, 8'h80};
    vecs[18] = '{8'h00, 8'h80, 1'b0, 1'b0, 3'd0, 8'h80};
    vecs[19] = '{8'h00, 8'h00, 1'b0, 1'b1, 3'd7, 8'h80};
    vecs[20] = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd7, 8'h00};
    vecs[21] = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd7, 8'h00};
    vecs[22] = '{8'h08, 8'h00, 1'b0, 1'b0, 3'd7, 8'h08};
    vecs[23] = '{8'h00, 8'h00, 1'b0, 1'b1, 3'd3, 8'h08};
    vecs[24] = '{8'h08, 8'h00, 1'b1, 1'b0, 3'd3, 8'h08};
    vecs[25] = '{8'h00, 8'h00, 1'b0, 1'b1, 3'd3, 8'h08};
    vecs[26] = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd3, 8'h00};

    #12;
    chk("reset.valid", {31'd0, bus.valid}, 32'd0);
    chk("reset.code",  {29'd0, bus.code},  32'd0);
    chk("reset.pend",  {24'd0, bus.pend},  32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    sb_en = 1'b1;

    for (int i = 0; i < 27; i++) begin
      logic prev_v;
      prev_v = (i == 0) ? 1'b0 : vecs[i-1].exp_valid;
      drive(vecs[i].req, vecs[i].mask, vecs[i].ack);
      if (vecs[i].exp_valid && !prev_v) sb_q.push_back(vecs[i].exp_code);
      cyc_chk($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_code, vecs[i].exp_pend);
    end
    sb_en = 1'b0;
    chk("sb_drained", sb_q.size(), 32'd0);

    // Held request across its own ack: level re-pends, edge capture does not.
    drive(8'h10, 8'h00, 1'b0);
    cyc_chk("hold.cap", 1'b0, 3'd0, 8'h10);
    cyc_chk("hold.grant", 1'b1, 3'd4, 8'h10);
    drive(8'h10, 8'h00, 1'b1);
`ifdef PR_REQ_EDGE_EN
    cyc_chk("hold.ack", 1'b0, 3'd0, 8'h00);
    drive(8'h10, 8'h00, 1'b0);
    cyc_chk("hold.noregrant", 1'b0, 3'd0, 8'h00);
`else
    cyc_chk("hold.ack", 1'b0, 3'd0, 8'h10);
    drive(8'h10, 8'h00, 1'b0);
    cyc_chk("hold.regrant", 1'b1, 3'd4, 8'h10);
`endif
    drive(8'h00, 8'h00, 1'b1);
    cyc_chk("hold.release", 1'b0, 3'd0, 8'h00);

    // Asynchronous reset in the middle of a presented grant.
    drive(8'h03, 8'h00, 1'b0);
    cyc_chk("ar.cap", 1'b0, 3'd0, 8'h03);
    drive(8'h00, 8'h00, 1'b0);
    cyc_chk("ar.grant", 1'b1, 3'd1, 8'h03);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.valid_now", {31'd0, bus.valid}, 32'd0);
    chk("ar.pend_now",  {24'd0, bus.pend},  32'd0);
    chk("ar.code_now",  {29'd0, bus.code},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'h00, 8'h00, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("ar.ack_valid", {31'd0, bus.valid}, 32'd0);
    chk("ar.ack_code",  {29'd0, bus.code},  32'd0);
    chk("ar.ack_pend",  {24'd0, bus.pend},  32'd0);
    drive(8'h00, 8'h00, 1'b0);

    // First capture after release happens at the first rising edge.
    drive(8'h40, 8'h00, 1'b0);
    cyc_chk("post_rst.cap", 1'b0, 3'd0, 8'h40);
    drive(8'h00, 8'h00, 1'b0);
    cyc_chk("post_rst.grant", 1'b1, 3'd6, 8'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pr_req_capture.md
PR_REQ_CAPTURE -- requirements
Module: pr_req_capture

Interface
REQ-001 No parameters; request width is fixed at 8 and code width at 3.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req  input  8  raw request lines; req[7] highest priority, req[0] lowest.
REQ-005 mask  input  8  per-line mask; 1 blocks that line from being granted, but it still latches.
REQ-006 ack  input  1  consumer acknowledge of the presented code.
REQ-007 valid  output  1  code holds a granted request.
REQ-008 code  output  3  binary index of the granted line.
REQ-009 pend  output  8  pending-request register, visible for debug.

Function
REQ-010 A pend bit shall be set at the rising edge where its capture condition is true (see REQ-022/023).
REQ-011 Eligible set = pend & ~mask; the winner shall be the highest set index in the eligible set.
REQ-012 State machine shall have two states: IDLE (valid=0) and PRESENT (valid=1).
REQ-013 IDLE: if eligible set is non-zero at an edge, code shall load the winner index and the state shall move to PRESENT; otherwise it shall stay IDLE.
REQ-014 PRESENT: code and valid shall hold stable until ack=1 is sampled, regardless of req, mask or new higher-priority pend bits.
REQ-015 PRESENT with ack=1: pend[code] shall clear, the state shall return to IDLE, and valid shall be 0 from that edge.
REQ-016 Grant latency: first eligible pend bit set at edge N gives valid=1 after edge N+1.
REQ-017 Back-to-back grants shall have exactly one idle cycle (valid=0) between them.
REQ-018 ack while in IDLE shall be ignored and shall have no effect on any state.
REQ-019 A set on a pend bit and an ack-clear of the same bit at the same edge: set wins, the bit remains 1, and it may be granted again.
REQ-020 Masking a line already presented shall not retract the grant; masked pend bits shall stay pending until unmasked and granted.
REQ-021 code shall retain its last value while valid=0 and shall be ignored by consumers.

Configuration
REQ-022 With macro PR_REQ_EDGE_EN defined: pend[i] sets only on a rising edge of req[i] (registered req_d, req & ~req_d), and req_d resets to 0.
REQ-023 Without PR_REQ_EDGE_EN: level capture, so pend[i] sets at every edge where req[i]=1, and a held request re-pends immediately after ack.

Reset
REQ-024 rst_n=0 shall immediately force: state=IDLE, valid=0, code=3'b000, pend=8'h00, req_d=8'h00.
REQ-025 Reset asserted mid-PRESENT shall drop the grant without ack, and all pending requests shall be lost.
REQ-026 After rst_n rises, the first capture shall occur at the first rising clk edge.

Verification
REQ-027 Single request: req=8'h01 for one cycle with mask=0 -> pend=8'h01, then valid=1 with code=0 one edge later; ack=1 -> valid=0 and pend=8'h00.
REQ-028 Priority: req=8'h24 in the same cycle -> code=5 first; after ack, one idle cycle, then code=2.
REQ-029 Hold and preempt: code=2 presented, then req[7] pulses with ack=0 for 5 cycles -> code stays 2 and valid stays 1; after ack, code=7 is next.
REQ-030 Mask: pend=8'h81 with mask=8'h80 -> code=0; after ack and mask=0 -> code=7.
REQ-031 Set/clear collision: code=3 presented, req[3] rising edge in the ack cycle -> pend[3]=1 remains and code=3 is regranted (both macro builds); with PR_REQ_EDGE_EN, req held high with no new edge after ack -> no regrant.
REQ-032 Async reset: rst_n=0 between clock edges during PRESENT -> valid=0 and pend=8'h00 immediately; after release, ack=1 -> no effect.
